fetch_stage: RTL

//   Instruction-fetch stage of PipelinedCPU: PC register, next-PC select, embedded instruction ROM and IF/ID pipeline register.

---
 rtl/riscv_pkg.sv | 26 ++
 rtl/instr_rom.sv | 25 ++
 rtl/fetch_stage.sv | 106 ++++++++++
 3 files changed

// File: rtl/riscv_pkg.sv
// Shared types and constants for the PipelinedCPU front end: datapath width,
// canonical NOP encoding and the IF/ID pipeline register layout.
package riscv_pkg;

    localparam int              XLEN             = 32;
    localparam logic [31:0]     NOP_INSTR        = 32'h0000_0013;
    localparam logic [XLEN-1:0] RESET_PC_DEFAULT = '0;

    typedef struct packed {
        logic [XLEN-1:0] pc;
        logic [XLEN-1:0] pc4;
        logic [31:0]     instr;
        logic            valid;
    } if_id_t;

    // Bubble pushed into IF/ID on reset, flush or redirect.
    function automatic if_id_t if_id_bubble();
        if_id_t b;
        b.pc    = '0;
        b.pc4   = XLEN'(4);
        b.instr = NOP_INSTR;
        b.valid = 1'b0;
        return b;
    endfunction

endpackage

// File: rtl/instr_rom.sv
// Instruction ROM with combinational read; words past IMEM_DEPTH read as NOP.
// Contents are written externally into rom_memory by the instantiating bench.
module instr_rom
    import riscv_pkg::*;
#(
    parameter int IMEM_DEPTH = 1024,
    parameter int AW         = XLEN - 2
) (
    input  logic [AW-1:0] word_addr_i,
    output logic [31:0]   instr_o
);

    localparam int IW = $clog2(IMEM_DEPTH);

    logic [31:0] rom_memory [IMEM_DEPTH];

    // NOTE: every output of an always_comb gets a default first, so no path leaves it unassigned and no latch is inferred.
    always_comb begin
        instr_o = NOP_INSTR;
        if (word_addr_i < AW'(IMEM_DEPTH)) begin
            instr_o = rom_memory[word_addr_i[IW-1:0]];
        end
    end

endmodule

// File: rtl/fetch_stage.sv
// Instruction-fetch stage: PC register, next-PC select, instruction ROM and IF/ID register.
// Define FETCH_MISALIGN_CHK_EN to trap misaligned redirect targets as a sticky fault.
module fetch_stage
    import riscv_pkg::*;
#(
    parameter int              XLEN       = 32,
    parameter int              IMEM_DEPTH = 1024,
    parameter logic [XLEN-1:0] RESET_PC   = RESET_PC_DEFAULT
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            stall_i,
    input  logic            flush_i,
    input  logic            redirect_i,
    input  logic [XLEN-1:0] redirect_pc_i,
    output logic [XLEN-1:0] if_id_pc_o,
    output logic [XLEN-1:0] if_id_pc4_o,
    output logic [31:0]     if_id_instr_o,
    output logic            if_id_valid_o,
    output logic            fetch_fault_o
);

    logic [XLEN-1:0] pc_q, pc_d;
    logic [XLEN-1:0] target;
    logic [31:0]     rom_instr;
    if_id_t          if_id_q, if_id_d;

    instr_rom #(
        .IMEM_DEPTH (IMEM_DEPTH),
        .AW         (XLEN - 2)
    ) imem_inst (
        .word_addr_i (pc_q[XLEN-1:2]),
        .instr_o     (rom_instr)
    );

`ifdef FETCH_MISALIGN_CHK_EN
    logic fault_q, fault_d;
    assign target = redirect_pc_i;
`else
    // Low bits are dropped silently; instructions are always word aligned.
    assign target = redirect_pc_i & ~XLEN'(3);
`endif

    always_comb begin
        pc_d    = pc_q;
        if_id_d = if_id_q;

        // Redirect outranks stall: the stalled instruction is on the wrong path.
        if (redirect_i) begin
            pc_d = target;
        end else if (!stall_i) begin
            pc_d = pc_q + XLEN'(4);
        end

        if (redirect_i || flush_i) begin
            if_id_d = if_id_bubble();
        end else if (!stall_i) begin
            if_id_d.pc    = pc_q;
            if_id_d.pc4   = pc_q + XLEN'(4);
            if_id_d.instr = rom_instr;
            if_id_d.valid = 1'b1;
        end

`ifdef FETCH_MISALIGN_CHK_EN
        fault_d = fault_q;
        if (redirect_i && (target[1:0] != 2'b00)) begin
            fault_d = 1'b1;
        end
        // Once faulted the stage is frozen until reset, ignoring all controls.
        if (fault_q) begin
            pc_d    = pc_q;
            if_id_d = if_id_bubble();
        end
`endif
    end

    // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            pc_q    <= RESET_PC;
            if_id_q <= if_id_bubble();
        end else begin
            pc_q    <= pc_d;
            if_id_q <= if_id_d;
        end
    end

`ifdef FETCH_MISALIGN_CHK_EN
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            fault_q <= 1'b0;
        end else begin
            fault_q <= fault_d;
        end
    end
    assign fetch_fault_o = fault_q;
`else
    assign fetch_fault_o = 1'b0;
`endif

    assign if_id_pc_o    = if_id_q.pc;
    assign if_id_pc4_o   = if_id_q.pc4;
    assign if_id_instr_o = if_id_q.instr;
    assign if_id_valid_o = if_id_q.valid;

endmodule
